// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo_bram: wrap-bit pointer arithmetic.
package sync_fifo_pkg;

  // Occupancy of a wrap-bit pointer pair: modular difference kept to cw bits.
  function automatic logic [31:0] ptr_diff(input logic [31:0] wr_p,
                                           input logic [31:0] rd_p,
                                           input int          cw);
    logic [31:0] mask;
    mask = (32'd1 << cw) - 32'd1;
    return (wr_p - rd_p) & mask;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple-dual-port RAM: one write port, one read port with registered output.
// Latency: read data valid the cycle after re_i; output holds when re_i is low.
// Backpressure: none; the caller guarantees read and write never share an address.
module fifo_ram_sdp #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array stays unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_bram.sv
// Single-clock BRAM FIFO with count, almost flags, error pulses; FIFO_FWFT_EN selects fall-through reads.
// Latency: standard read data one cycle after rd_en; FWFT head visible two edges after a write into empty.
// Backpressure: writes refused while full (overflow pulse), reads refused while empty (underflow pulse).
module sync_fifo_bram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int DATA_DEPTH    = 1024,
  parameter int AFULL_THRESH  = DATA_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        full,
  output logic                        almost_full,
  output logic                        overflow,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        empty,
  output logic                        almost_empty,
  output logic                        underflow,
  output logic [$clog2(DATA_DEPTH):0] count
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_TH = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_TH = CW'(AEMPTY_THRESH);

  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt;
  logic          ram_full, ram_empty, wr_acc, ram_re;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;

  assign ram_cnt   = CW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), CW));
  assign ram_full  = (ram_cnt == CW'(DATA_DEPTH));
  assign ram_empty = (ram_cnt == '0);
  assign wr_acc    = wr_en && !ram_full;

`ifdef FIFO_FWFT_EN
  // RAM output register is the head slot; refill it whenever it is free or being popped.
  logic out_valid_q, out_valid_d, pop;

  assign pop    = rd_en && out_valid_q;
  assign ram_re = !ram_empty && (!out_valid_q || pop);
  assign empty  = !out_valid_q;
  assign count  = ram_cnt + CW'(out_valid_q);
  assign rd_valid = 1'b0;

  always_comb begin
    out_valid_d = out_valid_q;
    if (ram_re)   out_valid_d = 1'b1;
    else if (pop) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid_q <= 1'b0;
    else        out_valid_q <= out_valid_d;
  end
`else
  logic rd_valid_q;

  assign ram_re   = rd_en && !ram_empty;
  assign empty    = ram_empty;
  assign count    = ram_cnt;
  assign rd_valid = rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_q <= 1'b0;
    else        rd_valid_q <= ram_re;
  end
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q + CW'(wr_acc);
    rd_ptr_d    = rd_ptr_q + CW'(ram_re);
    overflow_d  = wr_en && ram_full;
    underflow_d = rd_en && empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign full         = ram_full;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  fifo_ram_sdp #(
    .DW    (DATA_WIDTH),
    .DEPTH (DATA_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

endmodule

// File: doc/sync_fifo_bram.md
# sync_fifo_bram

Synchronous single-clock FIFO built on an inferred simple-dual-port block RAM, parametrised in width, depth and flag thresholds. It adds what a bare dual-port RAM lacks: wrap-bit pointer management, full/empty and programmable almost flags, an occupancy count, overflow/underflow error pulses, and an optional first-word-fall-through read mode. It is the general buffering element between streaming producers and consumers sharing one clock domain.

## Interface
- DATA_WIDTH, 16, word width in bits
- DATA_DEPTH, 1024, RAM words; power of two, ≥ 4
- AFULL_THRESH, DATA_DEPTH-4, almost_full asserts when count ≥ this
- AEMPTY_THRESH, 4, almost_empty asserts when count ≤ this
- Derived: AW = $clog2(DATA_DEPTH); CW = AW+1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- full  out  1  RAM holds DATA_DEPTH words; writes rejected
- almost_full  out  1  count ≥ AFULL_THRESH
- overflow  out  1  one-cycle pulse: wr_en while full
- rd_en  in  1  read request (pop)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data carries a newly read word (standard mode only; tied 0 under FWFT)
- empty  out  1  no readable word
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- underflow  out  1  one-cycle pulse: rd_en while empty
- count  out  CW  words held (see Operation)

## Operation
- Pointers wr_ptr, rd_ptr: CW bits, MSB is wrap bit; RAM address = low AW bits. Increment modulo 2^CW.
- ram_cnt = wr_ptr − rd_ptr (CW-bit modular). full = (ram_cnt == DATA_DEPTH). RAM empty = (ram_cnt == 0).
- Write accepted iff wr_en && !full; word stored at wr_ptr, wr_ptr++. Rejected write: no state change, overflow pulses.
- Read accepted iff rd_en && !empty; rejected read: no state change, underflow pulses.
- Flags decided on current-cycle state: simultaneous rd/wr when full → read accepted, write rejected (overflow=1); when empty → write accepted, read rejected (underflow=1). Otherwise both accepted, count unchanged.
- All outputs driven from registers or from registered pointers only; no combinational path from wr_en/rd_en/wr_data to any output.
- Standard mode: empty = (ram_cnt == 0); count = ram_cnt; capacity DATA_DEPTH. rd_data holds last value between reads.
- Reset: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0. RAM contents not reset. Reset mid-operation discards all data immediately (asynchronous).

## Timing
- Standard mode: accepted read at edge k → rd_data and rd_valid=1 in cycle after edge k; rd_valid low otherwise. Write at edge k → empty low after edge k; back-to-back read at edge k+1 returns that word.
- Flags/count update on the same edge as the accepting pointer change.
- overflow/underflow: high exactly the cycle after the offending edge, one cycle per rejected request.

## Configuration
- FIFO_FWFT_EN defined: first-word fall-through. RAM output register doubles as head register with out_valid bit. Prefetch (RAM read, rd_ptr++) whenever ram_cnt>0 and (!out_valid or head popped this edge). empty = !out_valid; rd_data = head word while !empty; rd_en pops. count = ram_cnt + out_valid; capacity DATA_DEPTH+1; full still = RAM full. Write into empty FIFO at edge k → empty low after edge k+1. Continuous rd_en with data available sustains one word per cycle.
- Undefined: standard mode as above.

## Structure
- Package sync_fifo_pkg: ptr_add/occupancy function for CW-bit modular difference; no typedefs beyond it.
- One sub-module: fifo_ram_sdp (write port addr/data/we, read port addr/en, registered resettable output); all pointer/flag logic in top.

## Test plan
- Reset, then 1024 writes of 0..1023 → full=1 after 1024th, count=1024, almost_full from 1020th; 1025th write → overflow pulse, count stays 1024.
- Drain 1024 reads → data 0..1023 in order, rd_valid per read, empty=1, almost_empty at count ≤4; extra read → underflow pulse, rd_data unchanged.
- Fill to 512, then 100 cycles simultaneous rd/wr → count stays 512, data order preserved; same at full and empty → rejected side flagged as specified.
- Wrap: 3 rounds of 700 writes then 700 reads → correct data across pointer MSB toggles, count never exceeds 700.
- Assert rst_n low mid-burst at count 300 → all outputs at reset values same cycle; subsequent write/read of 0xBEEF returns 0xBEEF.
- FWFT build: write 0x1234 into empty → empty low 2 edges later, rd_data=0x1234 without rd_en; fill to count 1025 → full=1; stream rd_en continuously → one word per cycle.
